// File: rtl/wb_write_arbiter.sv
// Two-source writeback arbiter for a single register-file write port.
// Each source owns a one-entry buffer; the older buffered entry wins the port.
module wb_write_arbiter #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int NREG   = 32
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              alu_valid_i,
  input  logic [ADDR_W-1:0] alu_addr_i,
  input  logic [DATA_W-1:0] alu_data_i,
  output logic              alu_ready_o,
  input  logic              mem_valid_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [DATA_W-1:0] mem_data_i,
  output logic              mem_ready_o,
  output logic              RegWrite_o,
  output logic [ADDR_W-1:0] RDaddr_o,
  output logic [DATA_W-1:0] RDdata_o,
  output logic [NREG-1:0]   busy_o
);

  // Handshake: a transfer happens on a rising edge where valid && ready.
  // Ready depends only on registered state, so there is no path from the
  // request inputs to any output.

  logic              full0, full1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [DATA_W-1:0] data0, data1;
  logic              old1;      // buffer 1 holds the older entry
  logic              old1_d;

  logic grant0, grant1;
  logic acc0, acc1, load0, load1, keep0, keep1;

  always_comb begin
    grant0 = full0 && (!full1 || !old1);
    grant1 = full1 && (!full0 || old1);
  end

  assign alu_ready_o = !full0 || grant0;
  assign mem_ready_o = !full1 || grant1;

  // Writes to x0 complete the handshake but are never buffered.
  assign acc0  = alu_valid_i && alu_ready_o;
  assign acc1  = mem_valid_i && mem_ready_o;
  assign load0 = acc0 && (alu_addr_i != '0);
  assign load1 = acc1 && (mem_addr_i != '0);
  assign keep0 = full0 && !grant0;
  assign keep1 = full1 && !grant1;

  // A newly loaded entry is younger than any surviving entry; on a tie the
  // MEM entry is older because it belongs to the earlier instruction.
  always_comb begin
    old1_d = old1;
    if (load0 && load1)
      old1_d = 1'b1;
    else if (load1)
      old1_d = !keep0;
    else if (load0)
      old1_d = keep1;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      full0 <= 1'b0;
      full1 <= 1'b0;
      addr0 <= '0;
      addr1 <= '0;
      data0 <= '0;
      data1 <= '0;
      old1  <= 1'b0;
    end else begin
      old1 <= old1_d;
      if (load0) begin
        full0 <= 1'b1;
        addr0 <= alu_addr_i;
        data0 <= alu_data_i;
      end else if (grant0) begin
        full0 <= 1'b0;
      end
      if (load1) begin
        full1 <= 1'b1;
        addr1 <= mem_addr_i;
        data1 <= mem_data_i;
      end else if (grant1) begin
        full1 <= 1'b0;
      end
    end
  end

  always_comb begin
    RegWrite_o = grant0 || grant1;
    RDaddr_o   = '0;
    RDdata_o   = '0;
    if (grant1) begin
      RDaddr_o = addr1;
      RDdata_o = data1;
    end else if (grant0) begin
      RDaddr_o = addr0;
      RDdata_o = data0;
    end
  end

  always_comb begin
    busy_o = '0;
    if (full0) busy_o[addr0] = 1'b1;
    if (full1) busy_o[addr1] = 1'b1;
  end

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Bench for wb_write_arbiter: directed scenarios plus random traffic against
// a sequence-number model of the two buffers and an in-order write queue.
module tb_wb_write_arbiter;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;
  localparam int NREG   = 32;
  localparam int W      = ADDR_W + DATA_W;

  logic              clk, rst_n;
  logic              alu_valid, mem_valid;
  logic [ADDR_W-1:0] alu_addr, mem_addr;
  logic [DATA_W-1:0] alu_data, mem_data;
  logic              alu_ready, mem_ready;
  logic              reg_write;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic [NREG-1:0]   busy;

  wb_write_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NREG(NREG)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .alu_valid_i(alu_valid), .alu_addr_i(alu_addr), .alu_data_i(alu_data),
    .alu_ready_o(alu_ready),
    .mem_valid_i(mem_valid), .mem_addr_i(mem_addr), .mem_data_i(mem_data),
    .mem_ready_o(mem_ready),
    .RegWrite_o(reg_write), .RDaddr_o(rd_addr), .RDdata_o(rd_data),
    .busy_o(busy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference model: each buffered entry carries its acceptance sequence
  // number; the lowest number owns the port. Writes leave in acceptance order.
  bit                m_full [2];
  logic [ADDR_W-1:0] m_addr [2];
  int                m_seq  [2];
  int                next_seq;
  bit                last_acc0, last_acc1;
  logic [W-1:0]      exp_q[$];
  logic [DATA_W-1:0] exp_rf [NREG];
  logic [DATA_W-1:0] act_rf [NREG];

  function automatic int m_grant();
    if (m_full[0] && m_full[1]) return (m_seq[0] < m_seq[1]) ? 0 : 1;
    if (m_full[0]) return 0;
    if (m_full[1]) return 1;
    return -1;
  endfunction

  task automatic model_reset();
    m_full[0] = 0; m_full[1] = 0;
    last_acc0 = 0; last_acc1 = 0;
    exp_q.delete();
  endtask

  // Advance the model across the coming rising edge using the driven inputs.
  task automatic model_step();
    int g;
    bit acc0, acc1;
    g = m_grant();
    acc0 = alu_valid && (!m_full[0] || g == 0);
    acc1 = mem_valid && (!m_full[1] || g == 1);
    last_acc0 = acc0;
    last_acc1 = acc1;
    if (g >= 0) m_full[g] = 0;
    if (acc1 && mem_addr != 0) begin
      m_full[1] = 1; m_addr[1] = mem_addr; m_seq[1] = next_seq++;
      exp_q.push_back({mem_addr, mem_data});
    end
    if (acc0 && alu_addr != 0) begin
      m_full[0] = 1; m_addr[0] = alu_addr; m_seq[0] = next_seq++;
      exp_q.push_back({alu_addr, alu_data});
    end
  endtask

  task automatic set_in(input bit av, input logic [ADDR_W-1:0] aa, input logic [DATA_W-1:0] ad,
                        input bit mv, input logic [ADDR_W-1:0] ma, input logic [DATA_W-1:0] md);
    alu_valid = av; alu_addr = aa; alu_data = ad;
    mem_valid = mv; mem_addr = ma; mem_data = md;
    model_step();
  endtask

  task automatic idle();
    set_in(0, 0, 0, 0, 0, 0);
  endtask

  // Random driver: a request that was not accepted is held unchanged.
  task automatic rand_in(input int pct, input bit nz);
    if (!(alu_valid && !last_acc0)) begin
      alu_valid = ($urandom_range(0, 99) < pct);
      alu_addr  = nz ? ADDR_W'($urandom_range(1, NREG-1)) : ADDR_W'($urandom_range(0, NREG-1));
      alu_data  = $urandom;
    end
    if (!(mem_valid && !last_acc1)) begin
      mem_valid = ($urandom_range(0, 99) < pct);
      mem_addr  = nz ? ADDR_W'($urandom_range(1, NREG-1)) : ADDR_W'($urandom_range(0, NREG-1));
      mem_data  = $urandom;
    end
    model_step();
  endtask

  // scoreboard: compare outputs against the model in mid-cycle
  task automatic tick();
    int g;
    logic [NREG-1:0] eb;
    logic [W-1:0] e;
    @(negedge clk);
    g  = m_grant();
    eb = '0;
    for (int p = 0; p < 2; p++) if (m_full[p]) eb[m_addr[p]] = 1'b1;
    chk("reg_write", 64'(reg_write), 64'(g >= 0));
    chk("alu_ready", 64'(alu_ready), 64'(!m_full[0] || g == 0));
    chk("mem_ready", 64'(mem_ready), 64'(!m_full[1] || g == 1));
    chk("busy", 64'(busy), 64'(eb));
    if (reg_write) act_rf[rd_addr] = rd_data;
    if (g >= 0) begin
      if (exp_q.size() == 0) begin
        chk("write_queue_nonempty", 64'(0), 64'(1));
      end else begin
        e = exp_q.pop_front();
        exp_rf[e[W-1:DATA_W]] = e[DATA_W-1:0];
        chk("write_entry", 64'({rd_addr, rd_data}), 64'(e));
      end
    end else begin
      chk("idle_addr_data", 64'({rd_addr, rd_data}), 64'(0));
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    for (int r = 0; r < NREG; r++) begin exp_rf[r] = '0; act_rf[r] = '0; end
    next_seq = 0;
    model_reset();
    rst_n = 1'b0;
    alu_valid = 0; alu_addr = 0; alu_data = 0;
    mem_valid = 0; mem_addr = 0; mem_data = 0;
    repeat (2) @(negedge clk);
    chk("reset_regwrite", 64'(reg_write), 64'(0));
    chk("reset_busy", 64'(busy), 64'(0));
    chk("reset_rdaddr", 64'(rd_addr), 64'(0));
    rst_n = 1'b1;
    #1;
    chk("reset_alu_ready", 64'(alu_ready), 64'(1));
    chk("reset_mem_ready", 64'(mem_ready), 64'(1));
    idle(); tick();

    // single write
    set_in(1, 5, 32'hDEADBEEF, 0, 0, 0); tick();
    chk("single_addr", 64'(rd_addr), 64'(5));
    chk("single_data", 64'(rd_data), 64'h0DEADBEEF);
    chk("single_busy", 64'(busy), 64'h20);
    idle(); tick();
    chk("single_busy_clear", 64'(busy), 64'(0));

    // simultaneous accept: MEM goes first
    set_in(1, 3, 32'h11, 1, 4, 32'h22); tick();
    chk("simul_first_addr", 64'(rd_addr), 64'(4));
    chk("simul_busy_both", 64'(busy), 64'h18);
    idle(); tick();
    chk("simul_second_addr", 64'(rd_addr), 64'(3));
    chk("simul_busy_one", 64'(busy), 64'h08);
    idle(); tick();
    chk("simul_busy_clear", 64'(busy), 64'(0));

    // same destination, MEM then ALU
    set_in(0, 0, 0, 1, 7, 32'hAAAA); tick();
    chk("samedst_first", 64'(rd_data), 64'hAAAA);
    set_in(1, 7, 32'hBBBB, 0, 0, 0); tick();
    chk("samedst_second", 64'(rd_data), 64'hBBBB);
    chk("samedst_busy", 64'(busy[7]), 64'(1));
    chk("samedst_final", 64'(act_rf[7]), 64'hBBBB);
    idle(); tick();
    chk("samedst_busy_clear", 64'(busy), 64'(0));

    // x0 write is dropped
    chk("x0_mem_ready", 64'(mem_ready), 64'(1));
    set_in(0, 0, 0, 1, 0, 32'hFFFFFFFF); tick();
    chk("x0_no_write", 64'(reg_write), 64'(0));
    chk("x0_no_busy", 64'(busy), 64'(0));
    idle(); tick();

    // back-pressure: both ports streaming
    alu_valid = 0; mem_valid = 0;
    rand_in(100, 1); tick();
    for (int i = 0; i < 7; i++) begin
      rand_in(100, 1); tick();
      chk("bp_one_write", 64'(reg_write), 64'(1));
    end
    alu_valid = 0; mem_valid = 0;
    repeat (3) begin idle(); tick(); end

    // random traffic
    for (int i = 0; i < 400; i++) begin
      rand_in((i < 200) ? 60 : 90, 0); tick();
    end
    alu_valid = 0; mem_valid = 0;
    repeat (3) begin idle(); tick(); end

    // reset mid-stream with both buffers full
    set_in(1, 9, 32'h99, 1, 10, 32'hA0); tick();
    rst_n = 1'b0;
    alu_valid = 0; mem_valid = 0;
    #1;
    chk("midreset_regwrite", 64'(reg_write), 64'(0));
    chk("midreset_busy", 64'(busy), 64'(0));
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("midreset_alu_ready", 64'(alu_ready), 64'(1));
    chk("midreset_mem_ready", 64'(mem_ready), 64'(1));
    repeat (3) begin idle(); tick(); end

    for (int r = 0; r < NREG; r++) chk("regfile", 64'(act_rf[r]), 64'(exp_rf[r]));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
